div32_seq: RTL and testbench

Sequential 32-bit integer divider for the MIPS execute stage, serving DIV and DIVU. Produces quotient (LO) and remainder (HI) in 33 cycles by restoring division: one 33-bit trial subtraction per cycle. Sits beside the ALU. The pipeline stalls on `busy` and writes HI/LO on `done`.

---
 rtl/div_pkg.sv | 19 +
 rtl/div32_seq_if.sv | 25 ++
 rtl/div32_step.sv | 30 +++
 rtl/div32_seq.sv | 127 ++++++++++++
 tb/tb_div32_seq.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared constants, state type and helpers for the sequential 32-bit divider.
package div_pkg;

    localparam int unsigned W        = 32;
    localparam int unsigned DIV_ITER = 32;
    localparam int unsigned CNT_W    = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } state_t;

    // Magnitude of x when treated as signed; 32'h80000000 maps to 2^31 unsigned.
    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
        return (sgn && x[W-1]) ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div32_seq_if.sv
// Request/result bundle between the execute stage and the divider.
interface div32_seq_if;
    import div_pkg::*;

    logic         start;
    logic         sign;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    modport master (
        output start, sign, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, sign, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );

endinterface

// File: rtl/div32_step.sv
// One restoring-division iteration: 33-bit trial subtract, shift quotient bit in.
module div32_step
    import div_pkg::*;
(
    input  logic [W:0]   r,
    input  logic [W-1:0] q,
    input  logic [W-1:0] dvs,
    output logic [W:0]   r_next,
    output logic [W-1:0] q_next
);

    logic [W:0] shifted;
    logic [W:0] trial;
    logic       fits;

    always_comb begin
        shifted = {r[W-1:0], q[W-1]};
        trial   = shifted - {1'b0, dvs};
        // A set top bit means the shifted remainder already exceeds any divisor.
        fits    = r[W] | ~trial[W];
        if (fits) begin
            r_next = trial;
            q_next = {q[W-2:0], 1'b1};
        end else begin
            r_next = shifted;
            q_next = {q[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div32_seq.sv
// Sequential 32-bit DIV/DIVU unit: 32 restoring iterations plus a sign-fixup cycle.
module div32_seq
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    div32_seq_if.slave  bus
);

    state_t             state, state_n;
    logic [CNT_W-1:0]   count, count_n;
    logic [W:0]         r, r_n;
    logic [W-1:0]       q, q_n;
    logic [W-1:0]       dvs, dvs_n;
    logic               neg_q, neg_q_n;
    logic               neg_r, neg_r_n;
    logic               dz, dz_n;
    logic [W-1:0]       quot, quot_n;
    logic [W-1:0]       rem, rem_n;
    logic               div_zero, div_zero_n;
    logic               done, done_n;
    logic [W:0]         step_r;
    logic [W-1:0]       step_q;

    div32_step u_step (
        .r      (r),
        .q      (q),
        .dvs    (dvs),
        .r_next (step_r),
        .q_next (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            r        <= '0;
            q        <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            div_zero <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            r        <= r_n;
            q        <= q_n;
            dvs      <= dvs_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            dz       <= dz_n;
            quot     <= quot_n;
            rem      <= rem_n;
            div_zero <= div_zero_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        count_n    = count;
        r_n        = r;
        q_n        = q;
        dvs_n      = dvs;
        neg_q_n    = neg_q;
        neg_r_n    = neg_r;
        dz_n       = dz;
        quot_n     = quot;
        rem_n      = rem;
        div_zero_n = div_zero;
        done_n     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    neg_q_n = bus.sign & (bus.dividend[W-1] ^ bus.divisor[W-1]);
                    neg_r_n = bus.sign & bus.dividend[W-1];
                    // Divide-by-zero skips RUN; q carries the raw dividend into FIX.
                    if (bus.divisor == '0) begin
                        dz_n    = 1'b1;
                        q_n     = bus.dividend;
                        state_n = ST_FIX;
                    end else begin
                        dz_n    = 1'b0;
                        r_n     = '0;
                        q_n     = mag(bus.dividend, bus.sign);
                        dvs_n   = mag(bus.divisor, bus.sign);
                        count_n = '0;
                        state_n = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                r_n     = step_r;
                q_n     = step_q;
                count_n = count + 1'b1;
                if (count == CNT_W'(DIV_ITER - 1))
                    state_n = ST_FIX;
            end
            ST_FIX: begin
                if (dz) begin
                    quot_n     = '1;
                    rem_n      = q;
                    div_zero_n = 1'b1;
                end else begin
                    quot_n     = neg_q ? (~q + 1'b1) : q;
                    rem_n      = neg_r ? (~r[W-1:0] + 1'b1) : r[W-1:0];
                    div_zero_n = 1'b0;
                end
                done_n  = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = done;
    assign bus.quotient  = quot;
    assign bus.remainder = rem;
    assign bus.div_zero  = div_zero;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq against an arithmetic reference model.
module tb_div32_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    div32_seq_if bus ();

    div32_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with truncation toward zero.
    task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eq, output logic [31:0] er, output logic edz);
        longint sa, sb;
        sa = s ? longint'($signed(a)) : longint'({32'b0, a});
        sb = s ? longint'($signed(b)) : longint'({32'b0, b});
        if (b == 32'd0) begin
            eq  = 32'hFFFF_FFFF;
            er  = a;
            edz = 1'b1;
        end else begin
            eq  = 32'(sa / sb);
            er  = 32'(sa % sb);
            edz = 1'b0;
        end
    endtask

    task automatic check_res(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        logic        edz;
        model(s, a, b, eq, er, edz);
        chk({tag, "_quot"}, bus.quotient, eq);
        chk({tag, "_rem"},  bus.remainder, er);
        chk({tag, "_dz"},   {31'b0, bus.div_zero}, {31'b0, edz});
    endtask

    task automatic drive(input logic st, input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.start    = st;
        bus.sign     = s;
        bus.dividend = a;
        bus.divisor  = b;
    endtask

    // Counts edges after the accept edge until done; optionally pulses start at edge pulse_at.
    task automatic wait_done(input int budget, input int pulse_at, input logic hold,
                             output int n, output int gaps);
        n = 0;
        gaps = 0;
        while (n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) break;
            if (!bus.busy) gaps++;
            if (!hold) begin
                if (pulse_at != 0 && n == pulse_at)
                    drive(1'b1, 1'($urandom), $urandom, $urandom);
                else
                    bus.start = 1'b0;
            end
        end
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int pulse_at);
        int n, gaps, lat;
        drive(1'b1, s, a, b);
        @(posedge clk);
        #1;
        drive(1'b0, 1'($urandom), $urandom, $urandom);
        chk({tag, "_busy_acc"}, {31'b0, bus.busy}, 32'd1);
        lat = (b == 32'd0) ? 1 : 33;
        wait_done(40, (b == 32'd0) ? 0 : pulse_at, 1'b0, n, gaps);
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_busy_gap"}, gaps, 0);
        chk({tag, "_busy_done"}, {31'b0, bus.busy}, 32'd0);
        check_res(tag, s, a, b);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
    endtask

    initial begin
        int n, gaps, dcount;
        logic        s;
        logic [31:0] a, b;

        drive(1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_quot", bus.quotient, 32'd0);
        chk("rst_rem",  bus.remainder, 32'd0);
        chk("rst_dz",   {31'b0, bus.div_zero}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 0);
        chk("k_100_7_q", bus.quotient, 32'd14);
        chk("k_100_7_r", bus.remainder, 32'd2);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        chk("k_m7_2_q", bus.quotient, 32'hFFFF_FFFD);
        chk("k_m7_2_r", bus.remainder, 32'hFFFF_FFFF);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        chk("k_7_m2_q", bus.quotient, 32'hFFFF_FFFD);
        chk("k_7_m2_r", bus.remainder, 32'd1);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("k_min_m1_q", bus.quotient, 32'h8000_0000);
        chk("k_min_m1_r", bus.remainder, 32'd0);
        run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("div_zero", 1'b0, 32'h0000_1234, 32'd0, 0);
        chk("k_dz_q", bus.quotient, 32'hFFFF_FFFF);
        chk("k_dz_r", bus.remainder, 32'h0000_1234);
        chk("k_dz_f", {31'b0, bus.div_zero}, 32'd1);
        run_op("ign_start", 1'b0, 32'd1000, 32'd3, 5);

        // Back-to-back: start held high through done.
        drive(1'b1, 1'b1, 32'hFFFF_FC18, 32'd9);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'hDEAD_BEEF, 32'd77);
        wait_done(40, 0, 1'b1, n, gaps);
        chk("b2b_lat_a", n, 33);
        check_res("b2b_a", 1'b1, 32'hFFFF_FC18, 32'd9);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, '0, '0);
        chk("b2b_busy_b", {31'b0, bus.busy}, 32'd1);
        chk("b2b_done_b", {31'b0, bus.done}, 32'd0);
        wait_done(40, 0, 1'b0, n, gaps);
        chk("b2b_lat_b", n, 33);
        check_res("b2b_b", 1'b0, 32'hDEAD_BEEF, 32'd77);

        // Reset during RUN discards the operation.
        drive(1'b1, 1'b0, 32'd5000, 32'd13);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, '0, '0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("mrst_done", {31'b0, bus.done}, 32'd0);
        chk("mrst_quot", bus.quotient, 32'd0);
        chk("mrst_rem",  bus.remainder, 32'd0);
        chk("mrst_dz",   {31'b0, bus.div_zero}, 32'd0);
        dcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) dcount++;
        end
        chk("mrst_no_done", dcount, 0);

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom % 4)
                0: b = $urandom;
                1: b = $urandom % 16;
                2: b = -($urandom % 16);
                default: b = $urandom >> ($urandom % 32);
            endcase
            if (i % 6 == 0) a = 32'h8000_0000;
            run_op($sformatf("rnd%0d", i), s, a, b, (i % 5 == 0) ? 5 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
